// File: rtl/fp_mul_seq.sv
// Sequential binary32 multiplier: radix-2 shift-add mantissa product, one partial product per
// clock, truncating rounding, subnormal flush, fixed 25-cycle latency for every operand class.
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] S
);

  typedef enum logic [1:0] {StIdle, StMul, StNorm} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  e1_q, e1_d, e2_q, e2_d;
  logic [23:0] m1_q, m1_d, m2_q, m2_d;
  logic [22:0] f2_q, f2_d;
  logic [47:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] s_q, s_d;
  logic        valid_q, valid_d;

  logic [24:0]        sum;
  logic               norm;
  logic [22:0]        mant;
  logic signed [9:0]  e_wide;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0]        result;

  // m2 is consumed by shifting, so its original fraction is kept in f2 for classification.
  assign a_nan  = (e1_q == 8'hFF) && (m1_q[22:0] != 23'd0);
  assign b_nan  = (e2_q == 8'hFF) && (f2_q != 23'd0);
  assign a_inf  = (e1_q == 8'hFF) && (m1_q[22:0] == 23'd0);
  assign b_inf  = (e2_q == 8'hFF) && (f2_q == 23'd0);
  assign a_zero = (e1_q == 8'h00);
  assign b_zero = (e2_q == 8'h00);

  assign sum    = {1'b0, p_q[47:24]} + (m2_q[0] ? {1'b0, m1_q} : 25'd0);
  assign norm   = p_q[47];
  assign mant   = norm ? p_q[46:24] : p_q[45:23];
  assign e_wide = $signed({2'b00, e1_q} + {2'b00, e2_q} + {9'd0, norm} - 10'd127);

  always_comb begin
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      result = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      result = {sign_q, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      result = {sign_q, 31'd0};
    end else if (e_wide >= 10'sd255) begin
      result = {sign_q, 8'hFF, 23'd0};
    end else if (e_wide <= 10'sd0) begin
      result = {sign_q, 31'd0};
    end else begin
      result = {sign_q, e_wide[7:0], mant};
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    f2_d    = f2_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = num1[31] ^ num2[31];
          e1_d    = num1[30:23];
          e2_d    = num2[30:23];
          m1_d    = {1'b1, num1[22:0]};
          m2_d    = {1'b1, num2[22:0]};
          f2_d    = num2[22:0];
          p_d     = '0;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        // Carry out of the upper-half add lands in P[47] after the right shift.
        p_d  = {sum, p_q[23:1]};
        m2_d = m2_q >> 1;
        if (cnt_q == 5'd23) begin
          state_d = StNorm;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StNorm: begin
        s_d     = result;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      f2_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      f2_q    <= f2_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign valid_out = valid_q;
  assign S         = s_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: result values, latency, handshake and reset behaviour.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic        busy;
  logic        valid_out;
  logic [31:0] S;

  int checks = 0;
  int errors = 0;

  fp_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num1      (num1),
    .num2      (num2),
    .busy      (busy),
    .valid_out (valid_out),
    .S         (S)
  );

  always #5 clk = ~clk;

  // Launches one op and waits (bounded) for valid_out; lat counts edges after the accept edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    num1  = a;
    num2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = S;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || S !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b S=%h, want 0 0 00000000", busy, valid_out, S);
    end
    start = 1'b1;
    num1  = 32'h3FC0_0000;
    num2  = 32'h4000_0000;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_start: busy=%b want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_normal;
    int busy_bad = 0;
    int lat = 0;
    @(negedge clk);
    num1  = 32'h3FC0_0000;
    num2  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num1  = 32'hFFFF_FFFF;
    num2  = 32'hFFFF_FFFF;
    for (int i = 0; i < 24; i++) begin
      if (busy !== 1'b1 || valid_out !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL normal_busy: %0d bad cycles, want 0", busy_bad);
    end
    @(posedge clk);
    #1;
    lat++;
    checks++;
    if (valid_out !== 1'b1 || busy !== 1'b0 || S !== 32'h4040_0000) begin
      errors++;
      $display("FAIL normal_result: lat=%0d valid=%b busy=%b S=%h, want valid 1 busy 0 S 40400000",
               lat, valid_out, busy, S);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0 || S !== 32'h4040_0000) begin
      errors++;
      $display("FAIL normal_pulse_width: valid=%b S=%h, want 0 40400000", valid_out, S);
    end
  endtask

  task automatic run_table(input string name, input logic [31:0] va[], input logic [31:0] vb[],
                           input logic [31:0] vexp[]);
    logic [31:0] res;
    int lat;
    for (int i = 0; i < va.size(); i++) begin
      do_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== vexp[i] || lat != 25) begin
        errors++;
        $display("FAIL %s[%0d]: %h*%h got S=%h lat=%0d, want S=%h lat=25",
                 name, i, va[i], vb[i], res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_normalize_sign;
    logic [31:0] va[]   = '{32'h3FC0_0000, 32'hC020_0000, 32'h3FC0_0000, 32'h3F80_0000};
    logic [31:0] vb[]   = '{32'h3FC0_0000, 32'h4080_0000, 32'h3F80_0001, 32'h3F80_0000};
    logic [31:0] vexp[] = '{32'h4010_0000, 32'hC120_0000, 32'h3FC0_0001, 32'h3F80_0000};
    run_table("normalize_sign", va, vb, vexp);
  endtask

  task automatic test_zero_flush;
    logic [31:0] va[]   = '{32'h8000_0000, 32'h0080_0000, 32'h0000_0001, 32'h0080_0000,
                            32'h0080_0000};
    logic [31:0] vb[]   = '{32'h4049_0FDB, 32'h0080_0000, 32'h3F80_0000, 32'h3F00_0000,
                            32'hBF80_0000};
    logic [31:0] vexp[] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                            32'h8080_0000};
    run_table("zero_flush", va, vb, vexp);
  endtask

  task automatic test_specials;
    logic [31:0] va[]   = '{32'h7F00_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0001,
                            32'h7F00_0000, 32'h3F80_0000};
    logic [31:0] vb[]   = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 32'h3F80_0000,
                            32'h4000_0000, 32'h7F80_0001};
    logic [31:0] vexp[] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                            32'h7F80_0000, 32'h7FC0_0000};
    run_table("specials", va, vb, vexp);
  endtask

  task automatic test_busy_ignore;
    int lat = 0;
    int extra = 0;
    @(negedge clk);
    num1  = 32'h3FC0_0000;
    num2  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (lat < 9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    num1  = 32'h4080_0000;
    num2  = 32'h4080_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!valid_out && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (S !== 32'h4040_0000 || lat != 25) begin
      errors++;
      $display("FAIL busy_ignore_result: S=%h lat=%0d, want 40400000 25", S, lat);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid_out || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_ignore_no_second_op: %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int first_at = 0;
    int second_at = 0;
    logic [31:0] s1 = '0;
    logic        busy_t25 = 1'b1;
    logic        busy_t26 = 1'b0;
    @(negedge clk);
    num1  = 32'h3FC0_0000;
    num2  = 32'h3FC0_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 1; t <= 51; t++) begin
      @(posedge clk);
      #1;
      if (t == 25) busy_t25 = busy;
      if (t == 26) busy_t26 = busy;
      if (valid_out) begin
        pulses++;
        if (first_at == 0) begin
          first_at = t;
          s1 = S;
        end else begin
          second_at = t;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 2 || first_at != 25 || second_at != 51) begin
      errors++;
      $display("FAIL back_to_back_timing: pulses=%0d at %0d,%0d, want 2 at 25,51",
               pulses, first_at, second_at);
    end
    checks++;
    if (busy_t25 !== 1'b0 || busy_t26 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_busy: T25=%b T26=%b, want 0 1", busy_t25, busy_t26);
    end
    checks++;
    if (s1 !== 32'h4010_0000 || S !== 32'h4010_0000) begin
      errors++;
      $display("FAIL back_to_back_result: S1=%h S2=%h, want 40100000", s1, S);
    end
  endtask

  task automatic test_reset_mid_op;
    int extra = 0;
    logic [31:0] res;
    int lat;
    @(negedge clk);
    num1  = 32'hC020_0000;
    num2  = 32'h4080_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || S !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op_state: busy=%b valid=%b S=%h, want 0 0 00000000",
               busy, valid_out, S);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid_out || busy || S !== 32'h0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_op_discard: %0d bad cycles, want 0", extra);
    end
    do_op(32'h3FC0_0000, 32'h4000_0000, res, lat);
    checks++;
    if (res !== 32'h4040_0000 || lat != 25) begin
      errors++;
      $display("FAIL reset_mid_op_recover: S=%h lat=%0d, want 40400000 25", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_normalize_sign();
    test_zero_flush();
    test_specials();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Sequential IEEE-754 single-precision multiplier; the arithmetic counterpart to the team's iterative divider in the ALU.
- Computes `S = a * b` with a radix-2 shift-add mantissa datapath: one partial product per clock.
- Uses a start/busy/valid_out handshake, so the ALU sequencer treats multiply and divide ops the same way.
- Truncates (round toward zero), flushes subnormals, and applies fixed latency to every operand class.

## Interface
No parameters; the format is fixed to binary32.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — request; sampled only while `busy`=0.
- `num1` input 32 — operand A; captured at the accepting edge.
- `num2` input 32 — operand B; captured at the accepting edge.
- `busy` output 1 — high from the accepting edge until the result edge.
- `valid_out` output 1 — one-cycle pulse; `S` is valid while it is high.
- `S` output 32 — result. Registered and held until the next result or reset.

## Operation
- **Reset:** on `rst`=1, state=IDLE and `busy`=0, `valid_out`=0, `S`=0x00000000. All internal registers are cleared.
- **State IDLE:** if `start`=1, latch the following and go to MUL:
  - sign = `num1[31]` ^ `num2[31]`
  - exponents e1, e2
  - mantissas m1={1,frac1}, m2={1,frac2} (24 bits each)
  - clear the 48-bit accumulator P and the 5-bit counter
  - raise `busy`
- **State MUL:** runs 24 cycles, each processing one multiplier bit.
  - If m2[0]=1, add m1 into P[47:24], with carry into a 49th bit.
  - Shift {carry,P} right by 1 and shift m2 right by 1.
  - After count reaches 23, go to NORM.
- **State NORM:** one cycle, then register `S`, pulse `valid_out`, drop `busy`, return to IDLE.
  - Normalization: norm = P[47]. Mantissa = norm ? P[46:24] : P[45:23]. Lower bits are discarded (truncate).
  - Exponent: computed as signed 10-bit, E = e1 + e2 − 127 + norm.
- **Result selection** (first match wins):
  1. Either operand has exponent 255 with nonzero fraction, or one operand is zero while the other is infinity → 0x7FC00000.
  2. Either operand is infinity → {sign, 8'hFF, 23'b0}.
  3. Either operand has exponent 0 (zero or subnormal) → {sign, 31'b0}.
  4. E ≥ 255 → {sign, 8'hFF, 23'b0}.
  5. E ≤ 0 → {sign, 31'b0}.
  6. Otherwise → {sign, E[7:0], mantissa}.
- **Fixed latency:** special cases still traverse MUL; classification uses the latched operands.
- **Busy behaviour:** `start` while `busy`=1 is ignored; there is no queueing. `num1`/`num2` may change freely after the accepting edge.

## Timing
- **Accept edge T0:** `start`=1 and `busy`=0. `busy`=1 after T0.
- **MUL iterations:** edges T1..T24.
- **Result edge T25:** NORM registers `S`. `valid_out`=1 and `busy`=0 from after T25 until T26.
- **Latency:** 25 clocks from accept to `valid_out`.
- **Back-to-back:** `start` held high at T25 is not accepted, because `busy`=1 at the sampling edge. The earliest next accept is T26, giving a throughput of one op per 26 clocks.
- **Reset mid-operation:** asserting `rst` at any time asynchronously forces reset values. The in-flight op is discarded and no `valid_out` is produced.
- **After reset release:** the first edge with `rst`=0 may accept `start`.

## Test plan
- **Normal, no normalize shift:** `num1`=0x3FC00000 (1.5), `num2`=0x40000000 (2.0) → after 25 clocks, `S`=0x40400000; `valid_out` high exactly 1 cycle; `busy` high for T1..T25.
- **Normalize path and sign:**
  - 0x3FC00000 × 0x3FC00000 → 0x40100000 (2.25).
  - 0xC0200000 × 0x40800000 → 0xC1200000 (−10.0).
- **Signed zero and flush:**
  - 0x80000000 × 0x40490FDB → 0x80000000.
  - 0x00800000 × 0x00800000 → 0x00000000 (underflow flush).
  - Subnormal 0x00000001 × 0x3F800000 → 0x00000000.
- **Overflow and specials:**
  - 0x7F000000 × 0x7F000000 → 0x7F800000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x00000000 × 0x7F800000 → 0x7FC00000.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000.
- **Handshake:**
  - Pulse `start` with new operands at T10 during an op → ignored, and the first result is unchanged.
  - Hold `start` continuously → accepts at T0 and T26 only; exactly one `valid_out` per op.
- **Reset mid-op:** assert `rst` at T12 for 1 cycle → `busy`=0, `S`=0, no `valid_out`. A new op 1.5×2.0 started after release completes with 0x40400000 after 25 clocks.
